// File: rtl/cover_event_sched.sv
// Coverage event scheduler: latches per-group hit vectors and emits them one index per cycle, round-robin across groups.
// Optional build macro COVER_DEDUP_EN adds a reported bitmap so that each point is emitted at most once between resets or clears.
module cover_grp_pe #(
    parameter int WIDTH = 8,
    parameter int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] bits,
    output logic             any,
    output logic [BW-1:0]    low
);
    always_comb begin
        any = |bits;
        low = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (bits[i]) low = BW'(i);
    end
endmodule

module cover_event_sched #(
    parameter int WIDTH      = 8,
    parameter int GROUPS     = 4,
    parameter int INDEX_BASE = 0,
    parameter int IDX_W      = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [GROUPS*WIDTH-1:0]  valid,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic [15:0]              report_count,
    output logic                     busy
);
    localparam int N  = GROUPS * WIDTH;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]                pending;
    logic [GW-1:0]               rr_ptr;
    logic [GROUPS-1:0]           grp_any;
    logic [GROUPS-1:0][BW-1:0]   grp_low;

    genvar g;
    generate
        for (g = 0; g < GROUPS; g++) begin : g_grp
            cover_grp_pe #(.WIDTH(WIDTH), .BW(BW)) u_pe (
                .bits (pending[g*WIDTH +: WIDTH]),
                .any  (grp_any[g]),
                .low  (grp_low[g])
            );
        end
    endgenerate

    // Round-robin group search starting at rr_ptr; first group with any pending bit wins.
    logic          found;
    logic [GW-1:0] sel_g, gi, rr_next;
    logic [BW-1:0] sel_b;
    logic [PW-1:0] sel_pt;
    always_comb begin
        found = 1'b0;
        sel_g = '0;
        gi    = '0;
        for (int k = 0; k < GROUPS; k++) begin
            gi = GW'((int'(rr_ptr) + k) % GROUPS);
            if (!found && grp_any[gi]) begin
                found = 1'b1;
                sel_g = gi;
            end
        end
        sel_b   = grp_low[sel_g];
        sel_pt  = PW'(int'(sel_g) * WIDTH + int'(sel_b));
        rr_next = (int'(sel_g) == GROUPS - 1) ? '0 : sel_g + 1'b1;
    end

    logic             fire, do_load;
    logic [N-1:0]     load_mask, pending_next;
    logic [IDX_W-1:0] next_index;

    assign fire       = out_valid && out_ready;
    assign do_load    = (!out_valid || out_ready) && !clear;
    assign load_mask  = (do_load && found) ? (N'(1) << sel_pt) : '0;
    assign next_index = IDX_W'(INDEX_BASE) + IDX_W'(sel_pt);
    assign busy       = (|pending) || out_valid;

`ifdef COVER_DEDUP_EN
    logic [N-1:0] reported;
    // Hits on reported points, or on the point leaving this edge, are dropped.
    assign pending_next = (pending & ~load_mask) | (valid & ~reported & ~load_mask);

    always_ff @(posedge clock) begin
        if (!reset || clear) reported <= '0;
        else                 reported <= reported | load_mask;
    end
`else
    // Set wins over the load-clear, so a same-edge re-hit is emitted again later.
    assign pending_next = (pending & ~load_mask) | valid;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending      <= '0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            report_count <= '0;
            rr_ptr       <= '0;
        end else if (clear) begin
            pending      <= '0;
            report_count <= '0;
            // A held event survives clear; one accepted on this edge is retired without counting.
            if (fire) out_valid <= 1'b0;
        end else begin
            pending <= pending_next;
            if (do_load) begin
                out_valid <= found;
                if (found) begin
                    out_index <= next_index;
                    rr_ptr    <= rr_next;
                end
            end
            if (fire && report_count != 16'hFFFF)
                report_count <= report_count + 16'd1;
        end
    end
endmodule

// File: doc/cover_event_sched.md
Name: cover_event_sched

Overview:
- Collects per-cycle coverage hit vectors from several toggle-coverage groups.
- Latches hits as pending and, with deduplication, suppresses points already reported.
- Serializes pending hits into one indexed event stream with a valid/ready handshake, round-robin across groups.
- Sits between the coverage-point instances and the single coverage-report sink, so the sink sees at most one index per cycle.

Parameters:
- WIDTH, 8: cover points per group.
- GROUPS, 4: number of groups (1..16).
- INDEX_BASE, 0: index of group 0 bit 0.
- IDX_W, 32: width of out_index.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low (0 = in reset), sampled on clock rising edge.
- valid  in  GROUPS*WIDTH  hit vector; bit g*WIDTH+b = group g point b hit this cycle.
- clear  in  1  synchronous re-arm: empties pending/reported maps and count.
- out_valid  out  1  event present.
- out_ready  in  1  sink accepts.
- out_index  out  IDX_W  INDEX_BASE + g*WIDTH + b.
- report_count  out  16  events accepted since reset/clear; saturates at 65535.
- busy  out  1  pending map nonzero or out_valid high.

Behaviour:
- Reset (reset==0 at edge): pending=0, reported=0, out_valid=0, out_index=0, report_count=0, rr_ptr=0. Reset overrides clear and all other inputs.
- State per point:
  - pending bit.
  - reported bit (dedup only, see Optional Feature).
- Hit capture: at edge, pending[i] <= 1 if valid[i] and point i is eligible. Eligible = not reported and not being loaded into output this edge. Otherwise pending is unchanged.
- Output stage: single register. It loads when out_valid==0 or (out_valid && out_ready). On load:
  - Selected point's pending bit cleared and its reported bit set.
  - out_valid=1 and out_index computed.
  - If no pending point exists, out_valid becomes 0.
- Selection:
  - Search groups starting at rr_ptr, wrapping modulo GROUPS; take the first group with any pending bit.
  - Within that group, take the lowest-numbered pending bit.
  - rr_ptr <= (selected group + 1) mod GROUPS. rr_ptr is unchanged when nothing is selected.
- Latency: hit in cycle c → pending visible in c+1 → out_valid in c+2 if the output stage is free. Selection reads registered pending only; same-cycle hits are not bypassed.
- Handshake:
  - out_index is stable while out_valid && !out_ready.
  - out_valid never drops without a fire, except on reset.
- report_count: +1 on each fire (out_valid && out_ready); saturates at 65535.
- clear (reset==1, clear==1):
  - pending, reported and report_count forced to 0, and valid ignored that edge.
  - A held output event is kept and delivered, but its fire does not increment the count if it occurs on the clear edge.
  - No new load on the clear edge.
- Index arithmetic: computed at IDX_W bits and wraps modulo 2^IDX_W.
- busy is combinational from registers.

Optional Feature:
- Macro: COVER_DEDUP_EN.
- Defined:
  - Reported bitmap present; each point is emitted at most once between reset/clear.
  - A hit on a reported point is dropped.
  - A hit on the point being loaded that edge is dropped.
- Undefined:
  - No reported bitmap.
  - Repeat hits while pending coalesce into one event.
  - A hit on the point being loaded that edge sets pending again (set wins), so it is emitted again later.

Test Plan (GROUPS=4, WIDTH=8, INDEX_BASE=100, out_ready=1 unless stated):
- Single hit: valid bit 3 for one cycle c → out_valid=1 only in cycle c+2 with out_index=103. report_count=1 after; busy=0 from c+3.
- Repeat hit: bit 3 again 10 cycles later → dedup: no event, count stays 1. Without COVER_DEDUP_EN: a second 103, count=2.
- All 32 bits hit in one cycle → 32 consecutive events in order 100,108,116,124,101,109,117,125,…,107,115,123,131; count=32; busy falls after the last fire.
- Backpressure: bit 9 hit, out_ready=0 for 5 cycles after out_valid rises → out_index=109 held stable all 5 cycles, count=0. Raise ready → one fire, count=1.
- Clear: bits 0 and 1 hit; clear pulsed while 100 is held → 100 delivered, 101 never emitted, count=0. Re-hit bit 0 → 100 emitted again, count=1.
- Reset mid-stream: reset=0 for one cycle during a 32-event burst → next cycle out_valid=0, busy=0, report_count=0. No further events without new hits.
